// File: rtl/sysmgr_rst_seq_if.sv
// sysmgr_rst_seq_if
//   Groups the lock/request inputs and the reset/status outputs of the
//   reset sequencer into one bundle. Clock and reset are not part of it.
//
//   Signals:
//     pll_lock       PLL lock indication, asynchronous to the sequencer clock
//     soft_rst       one-cycle software reset request
//     rst_out        per-domain active-high reset, bit i = domain i
//     ready          high when every domain is released
//     state          sequencer FSM state, for debug
//     lock_loss_cnt  lock-loss event counter (zero when the counter is not built)
//
//   Modports:
//     master  the side that drives lock/requests and observes resets
//     slave   the sequencer itself
interface sysmgr_rst_seq_if #(
  parameter int N_DOMAINS = 3
);
  logic                 pll_lock;
  logic                 soft_rst;
  logic [N_DOMAINS-1:0] rst_out;
  logic                 ready;
  logic [2:0]           state;
  logic [7:0]           lock_loss_cnt;

  modport master (
    output pll_lock,
    output soft_rst,
    input  rst_out,
    input  ready,
    input  state,
    input  lock_loss_cnt
  );

  modport slave (
    input  pll_lock,
    input  soft_rst,
    output rst_out,
    output ready,
    output state,
    output lock_loss_cnt
  );
endinterface

// File: rtl/sysmgr_rst_seq.sv
// sysmgr_rst_seq
//   Reset sequencer. Synchronises and glitch-filters the PLL lock, then
//   releases N_DOMAINS active-high resets in index order, STAGE_CYCLES apart.
//   Lock loss sends the FSM to FAULT for HOLDOFF cycles; a software request
//   restarts from WAIT_LOCK. All resets are re-asserted in both cases.
//
//   Ports:
//     clk_in  system clock (only clock)
//     rst_in  asynchronous active-high reset
//     bus     sysmgr_rst_seq_if.slave: pll_lock, soft_rst in;
//             rst_out, ready, state, lock_loss_cnt out (all registered)
//
//   Parameters (legal ranges):
//     N_DOMAINS >= 1, SYNC_STAGES >= 2, LOCK_FILTER >= 1,
//     STAGE_CYCLES >= 1, HOLDOFF >= 1
//
//   Build option:
//     SYSMGR_LOCK_LOSS_CNT_EN  when defined, lock_loss_cnt is an 8-bit
//       saturating count of SEQ/RUN -> FAULT transitions, cleared only by
//       rst_in. When undefined, lock_loss_cnt is tied to zero.
module sysmgr_rst_seq #(
  parameter int N_DOMAINS    = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_FILTER  = 16,
  parameter int STAGE_CYCLES = 128,
  parameter int HOLDOFF      = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  sysmgr_rst_seq_if.slave   bus
);

  // One counter serves FILTER, SEQ and FAULT, so size it for the longest.
  localparam int MAX_AB = (LOCK_FILTER > STAGE_CYCLES) ? LOCK_FILTER : STAGE_CYCLES;
  localparam int MAX_C  = (MAX_AB > HOLDOFF) ? MAX_AB : HOLDOFF;
  localparam int CNT_W  = $clog2(MAX_C + 1);
  localparam int IDX_W  = $clog2(N_DOMAINS + 1);

  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_DOMAINS - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_FILTER    = 3'd1,
    ST_SEQ       = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                 ready_q, ready_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                 lock_s;
  logic [N_DOMAINS-1:0] stage_sel;

  // Lock synchroniser: plain shift chain, the FSM only ever sees the last flop.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
  assign lock_s = sync_q[SYNC_STAGES-1];

  // One-hot decode of the domain currently being released. Clearing only the
  // selected bit guarantees release strictly in index order.
  for (genvar gi = 0; gi < N_DOMAINS; gi++) begin : g_stage_sel
    assign stage_sel[gi] = (idx_q == IDX_W'(gi));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        rst_out_d = '1;
        ready_d   = 1'b0;
        if (lock_s) begin
          state_d = ST_FILTER;
          cnt_d   = '0;
        end
      end

      ST_FILTER: begin
        rst_out_d = '1;
        ready_d   = 1'b0;
        if (!lock_s) begin
          // A lock glitch before sequencing is not a fault, just a restart.
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (bus.soft_rst) begin
          cnt_d = '0;
        end else if (cnt_q == FILTER_LAST) begin
          state_d = ST_SEQ;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SEQ, ST_RUN: begin
        if (!lock_s) begin
          // Lock loss outranks a simultaneous software request.
          state_d   = ST_FAULT;
          cnt_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
        end else if (bus.soft_rst) begin
          state_d   = ST_WAIT_LOCK;
          cnt_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
        end else if (state_q == ST_RUN) begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end else if (cnt_q == STAGE_LAST) begin
          rst_out_d = rst_out_q & ~stage_sel;
          cnt_d     = '0;
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FAULT: begin
        rst_out_d = '1;
        ready_d   = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_WAIT_LOCK;
        cnt_d     = '0;
        idx_d     = '0;
        rst_out_d = '1;
        ready_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      sync_q    <= sync_d;
    end
  end

  assign bus.rst_out = rst_out_q;
  assign bus.ready   = ready_q;
  assign bus.state   = state_q;

`ifdef SYSMGR_LOCK_LOSS_CNT_EN
  logic       fault_entry;
  logic [7:0] ll_cnt_q, ll_cnt_d;

  // Same condition that moves SEQ/RUN into FAULT in the FSM above.
  assign fault_entry = ((state_q == ST_SEQ) || (state_q == ST_RUN)) && !lock_s;

  always_comb begin
    ll_cnt_d = ll_cnt_q;
    if (fault_entry && (ll_cnt_q != 8'hFF)) begin
      ll_cnt_d = ll_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ll_cnt_q <= 8'h00;
    end else begin
      ll_cnt_q <= ll_cnt_d;
    end
  end

  assign bus.lock_loss_cnt = ll_cnt_q;
`else
  assign bus.lock_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_sysmgr_rst_seq.sv
// tb_sysmgr_rst_seq
//   Directed bench for sysmgr_rst_seq with N_DOMAINS=3, SYNC_STAGES=2,
//   LOCK_FILTER=4, STAGE_CYCLES=8, HOLDOFF=5. Edge numbers count from the
//   first clock edge after rst_in is released (that edge samples pll_lock=1).
module tb_sysmgr_rst_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   ecount;

`ifdef SYSMGR_LOCK_LOSS_CNT_EN
  localparam int LL_STEP = 1;
`else
  localparam int LL_STEP = 0;
`endif

  sysmgr_rst_seq_if #(.N_DOMAINS(3)) bus_if ();

  sysmgr_rst_seq #(
    .N_DOMAINS   (3),
    .SYNC_STAGES (2),
    .LOCK_FILTER (4),
    .STAGE_CYCLES(8),
    .HOLDOFF     (5)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, ecount, got, exp);
    end else begin
      $display("ok   %s edge=%0d val=%0h", tag, ecount, got);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic run_to(input int n);
    while (ecount < n) step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ecount = 0;
    rst = 1'b1;
    bus_if.pll_lock = 1'b1;
    bus_if.soft_rst = 1'b0;

    // 1. Held in reset with lock high and the clock running.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_rst_out", 32'(bus_if.rst_out), 32'h7);
      chk("rst_ready", 32'(bus_if.ready), 32'h0);
      chk("rst_state", 32'(bus_if.state), 32'h0);
      chk("rst_llcnt", 32'(bus_if.lock_loss_cnt), 32'h0);
    end

    // 2. Bring-up with lock held high.
    rst = 1'b0;
    ecount = 0;
    run_to(2);  chk("bu_state_e2", 32'(bus_if.state), 32'h0);
    run_to(3);  chk("bu_state_e3", 32'(bus_if.state), 32'h1);
    run_to(6);  chk("bu_state_e6", 32'(bus_if.state), 32'h1);
    run_to(7);  chk("bu_state_e7", 32'(bus_if.state), 32'h2);
    run_to(14); chk("bu_rst_e14", 32'(bus_if.rst_out), 32'h7);
    run_to(15); chk("bu_rst_e15", 32'(bus_if.rst_out), 32'h6);
    run_to(22); chk("bu_rst_e22", 32'(bus_if.rst_out), 32'h6);
    run_to(23); chk("bu_rst_e23", 32'(bus_if.rst_out), 32'h4);
    run_to(30); chk("bu_ready_e30", 32'(bus_if.ready), 32'h0);
    run_to(31);
    chk("bu_rst_e31", 32'(bus_if.rst_out), 32'h0);
    chk("bu_ready_e31", 32'(bus_if.ready), 32'h1);
    chk("bu_state_e31", 32'(bus_if.state), 32'h3);

    // 3. One-cycle lock glitch during FILTER, from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    ecount = 0;
    run_to(3);  chk("gl_state_e3", 32'(bus_if.state), 32'h1);
    bus_if.pll_lock = 1'b0;
    run_to(4);
    bus_if.pll_lock = 1'b1;
    run_to(5);  chk("gl_state_e5", 32'(bus_if.state), 32'h1);
    run_to(6);
    chk("gl_state_e6", 32'(bus_if.state), 32'h0);
    chk("gl_rst_e6", 32'(bus_if.rst_out), 32'h7);
    run_to(7);  chk("gl_state_e7", 32'(bus_if.state), 32'h1);
    run_to(18); chk("gl_rst_e18", 32'(bus_if.rst_out), 32'h7);
    run_to(19); chk("gl_rst_e19", 32'(bus_if.rst_out), 32'h6);
    run_to(35);
    chk("gl_ready_e35", 32'(bus_if.ready), 32'h1);
    chk("gl_state_e35", 32'(bus_if.state), 32'h3);

    // 4. Lock loss in RUN; lock returns during FAULT and must be ignored there.
    bus_if.pll_lock = 1'b0;
    run_to(37);
    chk("ll_ready_e37", 32'(bus_if.ready), 32'h1);
    chk("ll_state_e37", 32'(bus_if.state), 32'h3);
    run_to(38);
    chk("ll_rst_e38", 32'(bus_if.rst_out), 32'h7);
    chk("ll_ready_e38", 32'(bus_if.ready), 32'h0);
    chk("ll_state_e38", 32'(bus_if.state), 32'h4);
    run_to(39);
    bus_if.pll_lock = 1'b1;
    run_to(42); chk("ll_state_e42", 32'(bus_if.state), 32'h4);
    run_to(43); chk("ll_state_e43", 32'(bus_if.state), 32'h0);
    run_to(44); chk("ll_state_e44", 32'(bus_if.state), 32'h1);
    run_to(71); chk("ll_ready_e71", 32'(bus_if.ready), 32'h0);
    run_to(72);
    chk("ll_ready_e72", 32'(bus_if.ready), 32'h1);
    chk("ll_rst_e72", 32'(bus_if.rst_out), 32'h0);
    chk("ll_llcnt", 32'(bus_if.lock_loss_cnt), 32'(LL_STEP));

    // 5. Software reset in RUN, sampled at edge 75.
    run_to(74);
    bus_if.soft_rst = 1'b1;
    run_to(75);
    bus_if.soft_rst = 1'b0;
    chk("sr_rst_e75", 32'(bus_if.rst_out), 32'h7);
    chk("sr_ready_e75", 32'(bus_if.ready), 32'h0);
    chk("sr_state_e75", 32'(bus_if.state), 32'h0);
    run_to(76);  chk("sr_state_e76", 32'(bus_if.state), 32'h1);
    run_to(103); chk("sr_ready_e103", 32'(bus_if.ready), 32'h0);
    run_to(104);
    chk("sr_ready_e104", 32'(bus_if.ready), 32'h1);
    chk("sr_llcnt", 32'(bus_if.lock_loss_cnt), 32'(LL_STEP));

    // 6a. soft_rst and lock loss seen together in SEQ: lock loss wins.
    run_to(105);
    bus_if.soft_rst = 1'b1;
    run_to(106);
    bus_if.soft_rst = 1'b0;
    run_to(111); chk("co_state_e111", 32'(bus_if.state), 32'h2);
    run_to(112);
    bus_if.pll_lock = 1'b0;
    run_to(114);
    chk("co_state_e114", 32'(bus_if.state), 32'h2);
    bus_if.soft_rst = 1'b1;
    run_to(115);
    bus_if.soft_rst = 1'b0;
    bus_if.pll_lock = 1'b1;
    chk("co_state_e115", 32'(bus_if.state), 32'h4);
    chk("co_llcnt", 32'(bus_if.lock_loss_cnt), 32'(2 * LL_STEP));

    // 6b. Asynchronous reset mid-SEQ, between edges.
    run_to(120); chk("ar_state_e120", 32'(bus_if.state), 32'h0);
    run_to(133);
    chk("ar_state_e133", 32'(bus_if.state), 32'h2);
    chk("ar_rst_e133", 32'(bus_if.rst_out), 32'h6);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_rst_async", 32'(bus_if.rst_out), 32'h7);
    chk("ar_ready_async", 32'(bus_if.ready), 32'h0);
    chk("ar_state_async", 32'(bus_if.state), 32'h0);
    chk("ar_llcnt_async", 32'(bus_if.lock_loss_cnt), 32'h0);
    step();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
